// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared state encoding and default terminal count for multi_timer
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } chan_state_e;

  // Full-scale count: 4095 ticks = 2.048 s at the 2 kHz game clock for WIDTH=12.
  function automatic logic [31:0] default_tc(input int unsigned width);
    return 32'((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// rtl/multi_timer_if.sv - control/status bundle between a timer bank and its user
interface multi_timer_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       i_Start;
  logic [CHANNELS-1:0]       i_Clear;
  logic [CHANNELS-1:0]       i_Pause;
  logic [CHANNELS-1:0]       i_Mode;
  logic                      i_LoadEn;
  logic [CW-1:0]             i_LoadCh;
  logic [WIDTH-1:0]          i_LoadVal;
  logic [CHANNELS*WIDTH-1:0] o_Count;
  logic [CHANNELS-1:0]       o_Expire;
  logic [CHANNELS-1:0]       o_Done;
  logic [CHANNELS-1:0]       o_Busy;

  modport master (
    output i_Start, i_Clear, i_Pause, i_Mode, i_LoadEn, i_LoadCh, i_LoadVal,
    input  o_Count, o_Expire, o_Done, o_Busy
  );

  modport slave (
    input  i_Start, i_Clear, i_Pause, i_Mode, i_LoadEn, i_LoadCh, i_LoadVal,
    output o_Count, o_Expire, o_Done, o_Busy
  );
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: state machine, counter and terminal-count register
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] DEFAULT_TC = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             pause,
  input  logic             mode,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             done,
  output logic             busy
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic [WIDTH-1:0] count_inc;
  logic             expire_q, expire_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tc_d      = tc_q;
    expire_d  = 1'b0;
    done_d    = done_q;
    // A periodic hit leaves count at TC; the following tick wraps to 0.
    count_inc = (count_q == tc_q) ? '0 : count_q + 1'b1;

    if (load_en) tc_d = load_val;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (start) begin
      count_d = '0;
      done_d  = 1'b0;
      if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = ST_RUN;
        if (tc_q == '0) begin
          expire_d = 1'b1;
          if (!mode) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end else if (state_q == ST_RUN || state_q == ST_PAUSED) begin
      if (pause) begin
        state_d = ST_PAUSED;
      end else begin
        // Release edge counts immediately so k paused cycles cost exactly k.
        state_d = ST_RUN;
        count_d = count_inc;
        if (count_inc == tc_q) begin
          expire_d = 1'b1;
          if (!mode) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      tc_q     <= DEFAULT_TC;
      expire_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      expire_q <= expire_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count  = count_q;
  assign expire = expire_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - bank of independent timer channels; load decode and output packing only
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int               WIDTH      = 12,
  parameter int               CHANNELS   = 4,
  parameter logic [WIDTH-1:0] DEFAULT_TC = WIDTH'(default_tc(WIDTH))
) (
  input  logic        clk_2K,
  input  logic        i_Reset,
  multi_timer_if.slave bus
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       load_sel;
  logic [CHANNELS*WIDTH-1:0] count_w;
  logic [CHANNELS-1:0]       expire_w;
  logic [CHANNELS-1:0]       done_w;
  logic [CHANNELS-1:0]       busy_w;

  // Channel numbers beyond CHANNELS never match, so such loads are dropped.
  always_comb begin
    load_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load_sel[c] = bus.i_LoadEn && (bus.i_LoadCh == CW'(c));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_TC (DEFAULT_TC)
    ) u_ch (
      .clk      (clk_2K),
      .rst_n    (i_Reset),
      .start    (bus.i_Start[g]),
      .clear    (bus.i_Clear[g]),
      .pause    (bus.i_Pause[g]),
      .mode     (bus.i_Mode[g]),
      .load_en  (load_sel[g]),
      .load_val (bus.i_LoadVal),
      .count    (count_w[g*WIDTH +: WIDTH]),
      .expire   (expire_w[g]),
      .done     (done_w[g]),
      .busy     (busy_w[g])
    );
  end

  assign bus.o_Count  = count_w;
  assign bus.o_Expire = expire_w;
  assign bus.o_Done   = done_w;
  assign bus.o_Busy   = busy_w;

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised bank of independent timer channels clocked from the 2 kHz game clock. It replaces the single fixed-width counter with its two-second flag. Each channel has a programmable terminal count, one-shot or periodic mode, pause, synchronous clear, a one-cycle expire pulse and a sticky done flag. The BlackJack control FSM uses it for dealer delays, display blink and timeout supervision.

## Interface
- WIDTH, 12, counter and terminal-count width
- CHANNELS, 4, number of independent channels (≥1)
- DEFAULT_TC, 2**WIDTH-1, terminal count loaded at reset (4095 = 2.048 s period at 2 kHz)
- clk_2K  in  1  the single clock; all logic on rising edge
- i_Reset  in  1  asynchronous, active-low reset
- i_Start  in  CHANNELS  per-channel start/restart strobe
- i_Clear  in  CHANNELS  per-channel synchronous clear strobe
- i_Pause  in  CHANNELS  per-channel level hold
- i_Mode  in  CHANNELS  0 = one-shot, 1 = periodic
- i_LoadEn  in  1  write strobe for terminal count
- i_LoadCh  in  max(1,$clog2(CHANNELS))  channel selected by i_LoadEn
- i_LoadVal  in  WIDTH  new terminal count
- o_Count  out  CHANNELS*WIDTH  packed counts, channel n at [n*WIDTH +: WIDTH]
- o_Expire  out  CHANNELS  one-cycle pulse per terminal-count hit
- o_Done  out  CHANNELS  sticky, one-shot completion
- o_Busy  out  CHANNELS  1 in RUN or PAUSED

## Operation
- Per-channel states: IDLE, RUN, PAUSED, DONE.
- Reset: state IDLE; count 0; TC = DEFAULT_TC; o_Expire, o_Done and o_Busy all 0.
- Priority per channel per edge: Clear > Start > Pause > count.
- Clear: count 0, state IDLE, o_Done 0. TC is kept.
- Start: count 0, o_Done 0. State becomes PAUSED if i_Pause=1, else RUN. A Start in RUN or DONE restarts the channel.
- RUN with i_Pause=1: count holds, state PAUSED. Releasing Pause returns to RUN; counting resumes on the next edge.
- RUN: count increments by 1 each edge, modulo 2^WIDTH. Comparison with TC is equality only.
- Terminal hit: on the edge where the count register takes the value TC (including the Start edge when TC=0), o_Expire is 1 for the following cycle.
  - One-shot: state DONE, count holds TC, o_Done 1.
  - Periodic: state stays RUN; next edge count wraps to 0.
- i_LoadEn writes TC[i_LoadCh] at once, in any state. If the new TC is below the current count, the counter runs through 2^WIDTH-1, wraps to 0, then hits TC. An out-of-range i_LoadCh is ignored.
- i_Mode is sampled every edge; changing it mid-run affects only the next terminal hit.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- All outputs are registered; no combinational path from input to output.
- Start at edge 0: o_Count=k after edge k.
  - First o_Expire is visible in the cycle after edge TC.
  - Periodic expire interval is TC+1 cycles; TC=0 in periodic mode gives o_Expire continuously high.
- Pause introduces zero-cycle skew: k paused cycles delay expiry by exactly k.
- Asserting reset mid-count returns every output to its reset value asynchronously. The first count occurs only after a Start following reset release.

## Structure
- Shared package/include multi_timer_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3) and the DEFAULT_TC expression.
- Sub-module timer_channel holds one channel's state machine, count and TC registers.
  - It is instantiated CHANNELS times in a generate loop.
  - The top level does only load decoding and output packing.

## Test plan
- Reset, then Start ch0 in one-shot with default TC → o_Expire[0] pulses once in the cycle after edge 4095; o_Done[0]=1; o_Count ch0 holds 4095; o_Busy[0]=0.
- Load TC=9 on ch1, periodic, Start → o_Expire[1] every 10 cycles; count sequence 0..9,0; 5 periods checked.
- Ch2 with TC=20: Start, then Pause for 7 cycles at count 5 → count holds 5 during the pause; expire arrives 27 cycles after the Start edge.
- Same-edge Clear+Start on ch3 → IDLE, count 0; Start+Pause → PAUSED at count 0; TC=0 one-shot Start → DONE on the next cycle.
- Ch0 running at count 50, then load TC=10 → counter wraps through 4095→0 and expires at 10.
- Assert i_Reset low mid-run on all channels → all outputs 0 immediately and TC restored to 4095; the same stimulus on channels 0–3 in parallel is checked for zero cross-channel interaction.
